sobol_dir_loader: RTL and testbench
===================================

Name: sobol_dir_loader

Overview:
- Runtime writer for the Sobol direction-number RAM that the Sobol generator reads.
- Takes one dimension's Joe-Kuo parameters (degree s, polynomial a, initial m_i) over a valid/ready handshake.
- Expands them into 32 Q0.32 direction numbers with the standard recurrence.
- Writes them, one per cycle, to RAM addresses dim*32+j. This replaces the fixed file-loaded table, so sequences can be re-seeded without resynthesis.

Parameters:
- M, 50, number of Sobol dimensions; RAM depth M*32.
- S_MAX, 12, maximum supported polynomial degree.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  parameter record valid
- cfg_ready  out  1  loader idle, record accepted when cfg_valid&&cfg_ready
- cfg_dim  in  $clog2(M)  target dimension
- cfg_s  in  $clog2(S_MAX+1)  degree s; 0 selects van der Corput
- cfg_a  in  S_MAX-1  coefficients; a_1 = bit s-2 … a_{s-1} = bit 0
- cfg_m  in  S_MAX*S_MAX  initial m_i for i=1..s, m_i at [(i-1)*S_MAX +: S_MAX]
- wr_en  out  1  RAM write strobe
- wr_addr  out  $clog2(M*32)  dim*32+j
- wr_data  out  32  direction number v[j]
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse after 32nd write
- err  out  1  one-cycle pulse on rejected record

Behaviour:
- Reset values: cfg_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0; state=IDLE; j=0; history cleared.
- States: IDLE, GEN, DONE.
- IDLE: cfg_ready=1. On handshake at edge T, latch all cfg_* fields.
  - If cfg_dim>=M or cfg_s>S_MAX: stay IDLE, err=1 during T+1, no writes.
  - Otherwise go to GEN with j=0.
- GEN: cfg_ready=0, busy=1. One registered write per cycle; wr_en=1 in cycles T+1..T+32 for j=0..31, and wr_addr=dim*32+j in that cycle. The j=31 write ends GEN and moves to DONE.
- DONE (cycle T+33): done=1, busy=0, cfg_ready=0. Return to IDLE, so cfg_ready=1 from T+34.
- Per-element arithmetic (32-bit, shifts logical, XOR only), v[] indexed from 0:
  - s=0: v[j] = 0x80000000 >> j.
  - j<s: v[j] = (m_{j+1} masked to j+1 LSBs) << (31-j). m_i bits at or above i are ignored; oddness is not checked.
  - j>=s: v[j] = v[j-s] ^ (v[j-s] >> s) ^ XOR over i=1..s-1 of (a_i ? v[j-i] : 0).
- History: keep the last S_MAX generated values in a register shift history. No RAM read-back.
- Exactly 32 writes per accepted valid record. No write ever targets addresses outside dim*32..dim*32+31.
- cfg_valid while not IDLE: ignored, record not consumed.
- Reset asserted mid-GEN: wr_en=0 from the next edge, all outputs return to reset values, no done. RAM contents for that dimension are partial and undefined.
- The generator must not read a dimension while it is being loaded; the system sequencer enforces this.

Test Plan:
- dim=0, s=0 -> wr_en cycles T+1..T+32; addr 0..31 with data 0x80000000, 0x40000000, …, 0x00000001; done at T+33; cfg_ready at T+34.
- dim=1, s=1, a=0, m_1=1 -> addr 32..35 data 0x80000000, 0xC0000000, 0xA0000000, 0xF0000000.
- dim=2, s=2, a=1 (a_1=1), m=1,3 -> addr 64..66 data 0x80000000, 0xC0000000, 0x60000000.
- m_1=0xFFF with s=1 -> masked to 1, v[0]=0x80000000. cfg_dim=50 (M=50) or cfg_s=13 -> err pulse at T+1, no wr_en, cfg_ready stays 1.
- Reset low at T+10 during the dim=3 load -> wr_en=0 at T+11, busy=0, done never asserted. A fresh dim=3 load then completes 32 writes to addr 96..127.
- Back-to-back: cfg_valid held high with two records -> second accepted at T+34; cfg_valid pulses during GEN are ignored; exactly 64 writes total.

Source files
------------

// File: rtl/sobol_dir_loader.sv
// Sobol direction-number loader: expands one dimension's Joe-Kuo parameters
// (s, a, m_i) into 32 Q0.32 direction numbers and writes them to RAM at dim*32+j.
module sobol_dir_loader #(
  parameter int M     = 50,
  parameter int S_MAX = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(M)-1:0]        cfg_dim,
  input  logic [$clog2(S_MAX+1)-1:0]  cfg_s,
  input  logic [S_MAX-2:0]            cfg_a,
  input  logic [S_MAX*S_MAX-1:0]      cfg_m,
  output logic                        wr_en,
  output logic [$clog2(M*32)-1:0]     wr_addr,
  output logic [31:0]                 wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int DW = $clog2(M);
  localparam int SW = $clog2(S_MAX+1);
  localparam int AW = $clog2(M*32);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  // h[0] is the newest value v[j-1]; h[k-1] holds v[j-k].
  typedef logic [S_MAX-1:0][31:0] hist_t;

  state_t                   state_q, state_d;
  logic [5:0]               j_q, j_d;
  logic [DW-1:0]            dim_q, dim_d;
  logic [SW-1:0]            s_q, s_d;
  logic [S_MAX-2:0]         a_q, a_d;
  logic [S_MAX*S_MAX-1:0]   m_q, m_d;
  hist_t                    hist_q, hist_d;
  logic                     wr_en_q, wr_en_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;
  logic                     err_q, err_d;
  logic [31:0]              v_next;
  logic                     cfg_bad;

  // Direction number v[j] from the parameters and the last S_MAX values.
  function automatic logic [31:0] dir_value(
    input logic [5:0]             j,
    input logic [SW-1:0]          s,
    input logic [S_MAX-2:0]       a,
    input logic [S_MAX*S_MAX-1:0] m,
    input hist_t                  h
  );
    int               ji;
    int               si;
    logic [31:0]      acc;
    logic [S_MAX-1:0] m_sel;
    logic [31:0]      m_ext;
    logic [S_MAX-2:0] a_shr;
    ji    = int'(j);
    si    = int'(s);
    acc   = '0;
    m_sel = '0;
    m_ext = '0;
    a_shr = '0;
    if (si == 0) begin
      acc = 32'h8000_0000 >> ji;
    end else if (ji < si) begin
      for (int i = 0; i < S_MAX; i++) begin
        if (i == ji) m_sel = m[i*S_MAX +: S_MAX];
      end
      m_ext = 32'(m_sel) & ((32'd1 << (ji + 1)) - 32'd1);
      acc   = m_ext << (31 - ji);
    end else begin
      for (int k = 1; k <= S_MAX; k++) begin
        if (k == si) acc = h[k-1] ^ (h[k-1] >> k);
      end
      for (int i = 1; i < S_MAX; i++) begin
        if (i < si) begin
          a_shr = a >> (si - 1 - i);
          if (a_shr[0]) acc = acc ^ h[i-1];
        end
      end
    end
    return acc;
  endfunction

  assign cfg_bad = (int'(cfg_dim) >= M) || (int'(cfg_s) > S_MAX);

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    dim_d     = dim_q;
    s_d       = s_q;
    a_d       = a_q;
    m_d       = m_q;
    hist_d    = hist_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    v_next    = '0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          dim_d = cfg_dim;
          s_d   = cfg_s;
          a_d   = cfg_a;
          m_d   = cfg_m;
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            // v[0] is written on the accepting edge, straight from the inputs.
            v_next    = dir_value(6'd0, cfg_s, cfg_a, cfg_m, '0);
            wr_en_d   = 1'b1;
            wr_addr_d = {cfg_dim, 5'd0};
            wr_data_d = v_next;
            hist_d    = '0;
            hist_d[0] = v_next;
            j_d       = 6'd1;
            state_d   = GEN;
          end
        end
      end
      GEN: begin
        if (j_q == 6'd32) begin
          state_d = DONE;
        end else begin
          v_next    = dir_value(j_q, s_q, a_q, m_q, hist_q);
          wr_en_d   = 1'b1;
          wr_addr_d = {dim_q, j_q[4:0]};
          wr_data_d = v_next;
          hist_d    = {hist_q[S_MAX-2:0], v_next};
          j_d       = j_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        j_d     = 6'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed in the combinational block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= '0;
      dim_q     <= '0;
      s_q       <= '0;
      a_q       <= '0;
      m_q       <= '0;
      // NOTE: the history is a small register file, not a RAM, so it is
      // cleared on reset along with the rest of the state.
      hist_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      dim_q     <= dim_d;
      s_q       <= s_d;
      a_q       <= a_d;
      m_q       <= m_d;
      hist_q    <= hist_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == GEN);
  assign done      = (state_q == DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sobol_dir_loader.sv
// Self-checking bench for sobol_dir_loader: scoreboard of expected RAM writes
// from an array-based reference model, plus per-cycle handshake/status checks.
module tb_sobol_dir_loader;

  localparam int M     = 50;
  localparam int S_MAX = 12;
  localparam int DW    = $clog2(M);
  localparam int SW    = $clog2(S_MAX+1);
  localparam int AW    = $clog2(M*32);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [DW-1:0]              cfg_dim;
  logic [SW-1:0]              cfg_s;
  logic [S_MAX-2:0]           cfg_a;
  logic [S_MAX*S_MAX-1:0]     cfg_m;
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic [31:0]                wr_data;
  logic                       busy;
  logic                       done;
  logic                       err;

  sobol_dir_loader #(.M(M), .S_MAX(S_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_dim   (cfg_dim),
    .cfg_s     (cfg_s),
    .cfg_a     (cfg_a),
    .cfg_m     (cfg_m),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  tests       = 0;
  int  fails       = 0;
  int  wr_count    = 0;
  int  done_count  = 0;
  int  err_count   = 0;
  int  exp_writes  = 0;
  int  exp_done    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: full 32-entry array built directly from the recurrence.
  task automatic push_expected(input int dim, input int s, input logic [S_MAX-2:0] a,
                               input logic [S_MAX*S_MAX-1:0] m);
    logic [31:0] v[32];
    logic [31:0] mi;
    for (int j = 0; j < 32; j++) begin
      if (s == 0) begin
        v[j] = 32'h8000_0000 >> j;
      end else if (j < s) begin
        mi   = {20'd0, m[j*S_MAX +: S_MAX]};
        mi   = mi & ((32'd1 << (j + 1)) - 32'd1);
        v[j] = mi << (31 - j);
      end else begin
        v[j] = v[j-s] ^ (v[j-s] >> s);
        for (int i = 1; i < s; i++) begin
          if (a[s-1-i]) v[j] = v[j] ^ v[j-i];
        end
      end
      sb_q.push_back('{dim*32 + j, v[j]});
    end
  endtask

  function automatic logic [S_MAX*S_MAX-1:0] rand_m();
    return (S_MAX*S_MAX)'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [31:0] stat();
    return 32'({wr_en, busy, done, cfg_ready, err});
  endfunction

  // Monitor: compares every RAM write against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_count++;
    if (err) err_count++;
    if (wr_en) begin
      wr_count++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_write: addr %0d data %08h, none expected", wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        check("sb_addr", 32'(wr_addr), 32'(e.addr));
        check("sb_data", wr_data, e.data);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cfg_ready), 32'd1);
  endtask

  task automatic send_rec(input int dim, input int s, input logic [S_MAX-2:0] a,
                          input logic [S_MAX*S_MAX-1:0] m, input bit pulse, input int rst_k);
    bit          ok;
    logic [31:0] exp_st;
    ok = (dim < M) && (s <= S_MAX);
    wait_ready();
    cfg_dim   = DW'(dim);
    cfg_s     = SW'(s);
    cfg_a     = a;
    cfg_m     = m;
    cfg_valid = 1'b1;
    if (ok) push_expected(dim, s, a, m);
    @(posedge clk);
    for (int k = 1; k <= (ok ? 34 : 3); k++) begin
      @(negedge clk);
      if (k == 1) cfg_valid = 1'b0;
      if (rst_k != 0 && k == rst_k + 1) begin
        check("rst_status", stat(), 32'b00010);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_pending", 32'(sb_q.size()), 32'(32 - rst_k));
        sb_q.delete();
        exp_writes += rst_k;
        repeat (2) @(negedge clk);
        check("rst_hold_status", stat(), 32'b00010);
        rst_n = 1'b1;
        return;
      end
      if (ok) exp_st = {27'd0, k <= 32, k <= 32, k == 33, k >= 34, 1'b0};
      else    exp_st = {27'd0, 1'b0, 1'b0, 1'b0, 1'b1, k == 1};
      check($sformatf("status_d%0d_k%0d", dim, k), stat(), exp_st);
      if (rst_k != 0 && k == rst_k) rst_n = 1'b0;
      if (pulse && k <= 32) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_dim   = DW'($urandom_range(0, 63));
        cfg_s     = SW'($urandom);
      end else if (k >= 33) begin
        cfg_valid = 1'b0;
      end
    end
    if (ok) begin
      exp_writes += 32;
      exp_done++;
    end
  endtask

  task automatic back_to_back();
    int n;
    wait_ready();
    cfg_dim   = DW'(5);
    cfg_s     = SW'(3);
    cfg_a     = 11'h1;
    cfg_m     = rand_m();
    cfg_valid = 1'b1;
    push_expected(5, 3, 11'h1, cfg_m);
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cfg_dim = DW'(9);
        cfg_s   = SW'(7);
        cfg_a   = 11'h2d;
        cfg_m   = rand_m();
        push_expected(9, 7, 11'h2d, cfg_m);
      end
      check($sformatf("b2b_status_k%0d", k), stat(),
            {27'd0, k <= 32, k <= 32, k == 33, k >= 34, 1'b0});
    end
    @(negedge clk);
    check("b2b_second_accept", stat(), 32'b11000);
    check("b2b_second_addr", 32'(wr_addr), 32'(9*32));
    cfg_valid = 1'b0;
    exp_writes += 64;
    exp_done   += 2;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_dim   = '0;
    cfg_s     = '0;
    cfg_a     = '0;
    cfg_m     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", stat(), 32'b00010);
    check("reset_addr", 32'(wr_addr), 32'd0);
    check("reset_data", wr_data, 32'd0);
    rst_n = 1'b1;

    send_rec(0, 0, 11'h0, '0, 1'b0, 0);
    send_rec(1, 1, 11'h0, 144'h1, 1'b0, 0);
    send_rec(2, 2, 11'h1, 144'h003001, 1'b0, 0);
    send_rec(4, 1, 11'h0, rand_m() | 144'hfff, 1'b0, 0);
    send_rec(50, 2, 11'h1, rand_m(), 1'b0, 0);
    send_rec(7, 13, 11'h3, rand_m(), 1'b0, 0);
    send_rec(3, 5, 11'h5, 144'h0123456789abcdef, 1'b0, 10);
    send_rec(3, 5, 11'h5, 144'h0123456789abcdef, 1'b0, 0);
    back_to_back();
    for (int r = 0; r < 6; r++) begin
      send_rec(int'($urandom_range(0, M-1)), int'($urandom_range(0, S_MAX)),
               11'($urandom), rand_m(), 1'b1, 0);
    end
    send_rec(49, 12, 11'h7ff, rand_m(), 1'b1, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("write_total", 32'(wr_count), 32'(exp_writes));
    check("done_total", 32'(done_count), 32'(exp_done));
    check("err_total", 32'(err_count), 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
